// File: rtl/lbus_host_ctrl.sv
// lbus_host_ctrl: initiator end of the SASEBO local bus.
// Converts upstream write/read burst commands (1..8 words at consecutive
// word addresses) into address/strobe/gap cycle sequences on lbus.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready=1
// ADDR  | current address driven, both strobes high
// WSTB  | current write word driven, lbus_wrn=0
// RSTB  | current address driven, lbus_rdn=0, lbus_do sampled last cycle
// GAP   | both strobes high, address kept, then next word or RESP
// RESP  | one-cycle rsp_valid pulse
module lbus_host_ctrl #(
  parameter int ADDR_CYC = 2,
  parameter int DATA_CYC = 2,
  parameter int RD_CYC   = 3,
  parameter int GAP_CYC  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_wr,
  input  logic [15:0]  cmd_addr,
  input  logic [2:0]   cmd_len,
  input  logic [127:0] cmd_wdata,
  output logic         rsp_valid,
  output logic [127:0] rsp_rdata,
  output logic         busy,
  output logic [15:0]  lbus_di_a,
  output logic         lbus_wrn,
  output logic         lbus_rdn,
  input  logic [15:0]  lbus_do
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WSTB, S_RSTB, S_GAP, S_RESP
  } state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] ADDR_LD = CW'(ADDR_CYC - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_CYC - 1);
  localparam logic [CW-1:0] RD_LD   = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [15:0]    addr, addr_nxt;
  logic [2:0]     len, len_nxt;
  logic [2:0]     idx, idx_nxt;
  logic           wr, wr_nxt;
  // Write words, left-aligned so the next word to send is always [127:112].
  logic [127:0]   wsh, wsh_nxt;
  logic [127:0]   rdata_nxt;

  logic           di_sel_hold;
  logic [15:0]    di_nxt;
  logic           wrn_nxt, rdn_nxt, rsp_nxt, busy_nxt, rdy_nxt;

  logic           accept, last;

  assign accept = cmd_valid & cmd_ready;
  assign last   = (cnt == '0);

  // State, counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      len       <= '0;
      idx       <= '0;
      wr        <= 1'b0;
      wsh       <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      len       <= len_nxt;
      idx       <= idx_nxt;
      wr        <= wr_nxt;
      wsh       <= wsh_nxt;
      rsp_rdata <= rdata_nxt;
    end
  end

  // Next-state, per-state cycle counting and burst bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    len_nxt   = len;
    idx_nxt   = idx;
    wr_nxt    = wr;
    wsh_nxt   = wsh;
    rdata_nxt = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ADDR;
          cnt_nxt   = ADDR_LD;
          addr_nxt  = cmd_addr;
          len_nxt   = cmd_len;
          wr_nxt    = cmd_wr;
          idx_nxt   = '0;
          // Highest used word first: push the used field to the top.
          wsh_nxt   = cmd_wdata << {3'd7 - cmd_len, 4'b0000};
          rdata_nxt = '0;
        end
      end
      S_ADDR: begin
        if (last) begin
          state_nxt = wr ? S_WSTB : S_RSTB;
          cnt_nxt   = wr ? DATA_LD : RD_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_WSTB: begin
        if (last) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LD;
          wsh_nxt   = {wsh[111:0], 16'h0000};
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RSTB: begin
        if (last) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LD;
          rdata_nxt = {rsp_rdata[111:0], lbus_do};
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (last) begin
          if (idx == len) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_ADDR;
            cnt_nxt   = ADDR_LD;
            addr_nxt  = addr + 16'd2;
            idx_nxt   = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so every output is a flop.
  always_comb begin
    di_sel_hold = 1'b0;
    di_nxt      = lbus_di_a;
    case (state_nxt)
      S_ADDR, S_RSTB, S_GAP: di_nxt = addr_nxt;
      S_WSTB:                di_nxt = wsh_nxt[127:112];
      default:               di_sel_hold = 1'b1;
    endcase
    if (di_sel_hold) di_nxt = lbus_di_a;
    wrn_nxt  = (state_nxt != S_WSTB);
    rdn_nxt  = (state_nxt != S_RSTB);
    rsp_nxt  = (state_nxt == S_RESP);
    busy_nxt = (state_nxt != S_IDLE);
    rdy_nxt  = (state_nxt == S_IDLE);
  end

  // Output registers; reset forces strobes high and aborts any burst.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lbus_di_a <= '0;
      lbus_wrn  <= 1'b1;
      lbus_rdn  <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      lbus_di_a <= di_nxt;
      lbus_wrn  <= wrn_nxt;
      lbus_rdn  <= rdn_nxt;
      rsp_valid <= rsp_nxt;
      busy      <= busy_nxt;
      cmd_ready <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_lbus_host_ctrl.sv
// Bench for lbus_host_ctrl: a transaction-level model expands each accepted
// command into the expected per-cycle bus trace; every cycle the DUT is
// compared against it. A responder returns valid read data only on the
// final rdn=0 cycle of each strobe.
module tb_lbus_host_ctrl;

  localparam int ADDR_CYC = 2;
  localparam int DATA_CYC = 2;
  localparam int RD_CYC   = 3;
  localparam int GAP_CYC  = 1;

  logic         clk;
  logic         rstn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_wr;
  logic [15:0]  cmd_addr;
  logic [2:0]   cmd_len;
  logic [127:0] cmd_wdata;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic         busy;
  logic [15:0]  lbus_di_a;
  logic         lbus_wrn;
  logic         lbus_rdn;
  logic [15:0]  lbus_do;

  lbus_host_ctrl #(
    .ADDR_CYC(ADDR_CYC), .DATA_CYC(DATA_CYC), .RD_CYC(RD_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .lbus_di_a(lbus_di_a), .lbus_wrn(lbus_wrn), .lbus_rdn(lbus_rdn),
    .lbus_do(lbus_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  di;
    logic         wrn;
    logic         rdn;
    logic         rsp;
    logic         bsy;
    logic         rdy;
    logic         ck_rd;
    logic [127:0] rd;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ent_t         q[$];
  bit           have_model = 0;
  logic [15:0]  m_di = '0;
  logic [127:0] m_rd = '0;
  int           rd_run = 0;
  bit           acc_flag = 0;

  int           acc_cyc = 0;
  int           rsp_cyc = 0;
  int           rsp_n = 0;
  int           wlow_n = 0;
  int           first_wlow = -1;
  logic [15:0]  last_wdi = '0;
  logic [15:0]  rsp_di = '0;
  logic [127:0] rsp_rd = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] di, input logic wrn, input logic rdn,
                              input logic rsp, input logic bsy, input logic rdy,
                              input logic ck_rd, input logic [127:0] rd);
    ent_t e;
    e.di = di; e.wrn = wrn; e.rdn = rdn; e.rsp = rsp;
    e.bsy = bsy; e.rdy = rdy; e.ck_rd = ck_rd; e.rd = rd;
    return e;
  endfunction

  // Responder memory contents (pure function of address).
  function automatic logic [15:0] resp_word(input logic [15:0] a);
    logic [15:0] r;
    if (a == 16'h0002) return 16'hABCD;
    if (a == 16'h0004) return 16'h1234;
    r = a * 16'h9E37;
    return r ^ 16'h1F1F;
  endfunction

  // Expand one accepted command into the cycles that must follow it.
  task automatic build_trace(input logic wr, input logic [15:0] a0,
                             input logic [2:0] len, input logic [127:0] wd);
    logic [127:0] rd;
    logic [127:0] t;
    logic [15:0]  a;
    logic [15:0]  word;
    rd = '0;
    a  = a0;
    for (int w = 0; w <= int'(len); w++) begin
      a = a0 + 16'(2 * w);
      for (int k = 0; k < ADDR_CYC; k++) q.push_back(mk(a, 1, 1, 0, 1, 0, 0, '0));
      if (wr) begin
        t = wd >> (16 * (int'(len) - w));
        word = t[15:0];
        for (int k = 0; k < DATA_CYC; k++) q.push_back(mk(word, 0, 1, 0, 1, 0, 0, '0));
      end else begin
        for (int k = 0; k < RD_CYC; k++) q.push_back(mk(a, 1, 0, 0, 1, 0, 0, '0));
        rd = {rd[111:0], resp_word(a)};
      end
      for (int k = 0; k < GAP_CYC; k++) q.push_back(mk(a, 1, 1, 0, 1, 0, 0, '0));
    end
    if (wr) rd = '0;
    q.push_back(mk(a, 1, 1, 1, 1, 0, 1, rd));
    m_di = a;
    m_rd = rd;
  endtask

  // One clock cycle: called at a falling edge with this cycle's inputs set.
  task automatic step();
    ent_t cur;
    if (have_model) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(m_di, 1, 1, 0, 0, 1, 1, m_rd);
      chk("lbus_di_a", lbus_di_a, cur.di);
      chk("lbus_wrn", lbus_wrn, cur.wrn);
      chk("lbus_rdn", lbus_rdn, cur.rdn);
      chk("rsp_valid", rsp_valid, cur.rsp);
      chk("busy", busy, cur.bsy);
      chk("cmd_ready", cmd_ready, cur.rdy);
      if (cur.ck_rd) chk("rsp_rdata", rsp_rdata, cur.rd);
    end else begin
      cur = mk('0, 1, 1, 0, 0, 0, 0, '0);
    end
    chk("strobes_both_low", (!lbus_wrn && !lbus_rdn), 1'b0);

    if (rsp_valid) begin
      rsp_n++; rsp_cyc = cyc; rsp_di = lbus_di_a; rsp_rd = rsp_rdata;
    end
    if (!lbus_wrn) begin
      wlow_n++; last_wdi = lbus_di_a;
      if (first_wlow < 0) first_wlow = cyc;
    end

    rd_run  = (!lbus_rdn) ? rd_run + 1 : 0;
    lbus_do = (rd_run == RD_CYC) ? resp_word(lbus_di_a) : 16'($urandom);

    acc_flag = 0;
    if (!rstn) begin
      q.delete();
      m_di = '0;
      m_rd = '0;
      q.push_back(mk('0, 1, 1, 0, 0, 0, 1, '0));
      have_model = 1;
    end else if (have_model && cur.rdy && cmd_valid) begin
      acc_flag = 1; acc_cyc = cyc; rsp_n = 0; wlow_n = 0; first_wlow = -1;
      build_trace(cmd_wr, cmd_addr, cmd_len, cmd_wdata);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [2:0] len,
                       input logic [127:0] wd);
    int n;
    cmd_wr = wr; cmd_addr = a; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (1) begin
      step();
      if (acc_flag) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (q.size() > 0) begin
      step();
      n++;
      if (n > 300) begin
        chk("idle_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, r1, hold_n;
    logic wr;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_wdata = '0; lbus_do = '0;
    @(negedge clk);
    repeat (3) step();
    chk("reset_ready_low", cmd_ready, 1'b0);
    chk("reset_wrn", lbus_wrn, 1'b1);
    rstn = 1'b1;
    step();
    chk("ready_after_reset", cmd_ready, 1'b1);

    // single write
    issue(1'b1, 16'h0002, 3'd0, 128'h1);
    wait_idle();
    chk("wr1_rsp_lat", 128'(rsp_cyc - acc_cyc), 128'd6);
    chk("wr1_first_wlow", 128'(first_wlow - acc_cyc), 128'd3);
    chk("wr1_wlow_n", 128'(wlow_n), 128'd2);
    chk("wr1_data", last_wdi, 16'h0001);
    chk("wr1_rdata", rsp_rd, 128'h0);

    // 8-word write
    issue(1'b1, 16'h0100, 3'd7, 128'h000102030405060708090A0B0C0D0E0F);
    wait_idle();
    chk("wr8_rsp_lat", 128'(rsp_cyc - acc_cyc), 128'd41);
    chk("wr8_wlow_n", 128'(wlow_n), 128'd16);
    chk("wr8_last_data", last_wdi, 16'h0E0F);
    chk("wr8_last_addr", rsp_di, 16'h010E);

    // 2-word read
    issue(1'b0, 16'h0002, 3'd1, '0);
    wait_idle();
    chk("rd2_rsp_lat", 128'(rsp_cyc - acc_cyc), 128'd13);
    chk("rd2_rdata", rsp_rd, 128'hABCD1234);
    chk("rd2_rsp_n", 128'(rsp_n), 128'd1);

    // address wrap
    issue(1'b1, 16'hFFFE, 3'd1, 128'h11112222);
    wait_idle();
    chk("wrap_addr", rsp_di, 16'h0000);
    chk("wrap_last_data", last_wdi, 16'h2222);

    // cmd_valid held across a whole burst and its RESP cycle
    issue(1'b1, 16'h0040, 3'd0, 128'hBEEF);
    a1 = acc_cyc;
    cmd_addr = 16'h0042; cmd_wdata = 128'hCAFE;
    issue(1'b1, 16'h0042, 3'd0, 128'hCAFE);
    r1 = rsp_cyc;
    chk("held_second_accept", 128'(acc_cyc - r1), 128'd1);
    chk("held_accept_gap", 128'(acc_cyc - a1), 128'd7);
    wait_idle();

    // reset in the middle of an 8-word write strobe
    issue(1'b1, 16'h0100, 3'd7, 128'h000102030405060708090A0B0C0D0E0F);
    cmd_valid = 1'b0;
    repeat (7) step();
    chk("mid_wstb_wrn", lbus_wrn, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_wrn", lbus_wrn, 1'b1);
    chk("rst_di", lbus_di_a, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    step();
    chk("rst_ready_again", cmd_ready, 1'b1);
    repeat (10) step();
    chk("rst_no_rsp", 128'(rsp_n), 128'd0);

    // randomized commands
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) step();
      wr = 1'($urandom_range(0, 1));
      issue(wr, 16'($urandom) & 16'hFFFE, 3'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        hold_n = $urandom_range(1, 4);
        for (int k = 0; k < hold_n; k++) begin
          cmd_addr = 16'($urandom); cmd_wdata = {4{$urandom}};
          step();
        end
      end
      cmd_valid = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(0, 20)) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
      end
      wait_idle();
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
